// File: rtl/load_align_unit_pkg.sv
// Shared load op codes, FSM states and size/sign helpers for the load align unit.
package load_align_unit_pkg;

    typedef enum logic [2:0] {
        LD_FULL = 3'b000,
        LD_BU   = 3'b001,
        LD_B    = 3'b010,
        LD_HU   = 3'b011,
        LD_H    = 3'b100,
        LD_WU   = 3'b101,
        LD_W    = 3'b110
    } ld_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP
    } state_e;

    // Word ops only exist on a 64-bit port; anything unknown collapses to a full-width load.
    function automatic ld_op_e normalize_op(input logic [2:0] op, input int unsigned dw);
        ld_op_e r;
        case (op)
            3'b001:  r = LD_BU;
            3'b010:  r = LD_B;
            3'b011:  r = LD_HU;
            3'b100:  r = LD_H;
            3'b101:  r = (dw == 64) ? LD_WU : LD_FULL;
            3'b110:  r = (dw == 64) ? LD_W : LD_FULL;
            default: r = LD_FULL;
        endcase
        return r;
    endfunction

    function automatic int unsigned op_bytes(input ld_op_e op, input int unsigned dw);
        int unsigned n;
        case (op)
            LD_BU, LD_B: n = 1;
            LD_HU, LD_H: n = 2;
            LD_WU, LD_W: n = 4;
            default:     n = dw / 8;
        endcase
        return n;
    endfunction

    function automatic logic op_signed(input ld_op_e op);
        return (op == LD_B) || (op == LD_H) || (op == LD_W);
    endfunction

endpackage

// File: rtl/load_align_unit_extract.sv
// Combinational merge: shifts the two-beat window down to the access offset and extends it.
module load_align_unit_extract
    import load_align_unit_pkg::*;
#(
    parameter int unsigned DW = 32,
    localparam int unsigned OFFW = $clog2(DW / 8)
) (
    input  logic [2*DW-1:0] window_i,
    input  logic [OFFW-1:0] off_i,
    input  ld_op_e          op_i,
    output logic [DW-1:0]   data_o
);

    logic [2*DW-1:0] shifted;
    logic            sign;
    int unsigned     nbytes;

    // Align the addressed bytes to bit 0, keep the access size, fill the rest with zero or sign.
    always_comb begin
        shifted = window_i >> {off_i, 3'b000};
        nbytes  = op_bytes(op_i, DW);
        case (op_i)
            LD_B:    sign = shifted[7];
            LD_H:    sign = shifted[15];
            LD_W:    sign = shifted[31];
            default: sign = 1'b0;
        endcase
        data_o = '0;
        for (int unsigned i = 0; i < DW / 8; i++) begin
            if (i < nbytes) begin
                data_o[i*8 +: 8] = shifted[i*8 +: 8];
            end else begin
                data_o[i*8 +: 8] = {8{sign}};
            end
        end
    end

endmodule

// File: rtl/load_align_unit.sv
// Load data path: one load at a time, one or two aligned memory beats, merged and extended.
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 32,
    parameter int unsigned MISALIGN_EN = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [2:0]    req_op,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err
);

    localparam int unsigned NB   = DW / 8;
    localparam int unsigned OFFW = $clog2(NB);

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    ld_op_e          op_q, op_d;
    logic            cross_q, cross_d;
    logic [DW-1:0]   beat0_q, beat0_d;
    logic [DW-1:0]   data_q, data_d;
    logic            err_q, err_d;

    ld_op_e          req_op_n;
    logic            req_cross;
    logic [AW-1:0]   base_addr;
    logic [2*DW-1:0] window;
    logic [DW-1:0]   merged;

    assign req_op_n  = normalize_op(req_op, DW);
    assign req_cross = (32'(req_addr[OFFW-1:0]) + op_bytes(req_op_n, DW)) > NB;
    assign base_addr = {addr_q[AW-1:OFFW], {OFFW{1'b0}}};

    // Merge straight from the arriving beat so the result register loads on the last beat.
    assign window = (state_q == S_WAIT1) ? {mem_rdata, beat0_q} : {{DW{1'b0}}, mem_rdata};

    load_align_unit_extract #(.DW(DW)) u_extract (
        .window_i (window),
        .off_i    (addr_q[OFFW-1:0]),
        .op_i     (op_q),
        .data_o   (merged)
    );

    assign req_ready     = (state_q == S_IDLE);
    assign mem_req_valid = (state_q == S_REQ0) || (state_q == S_REQ1);
    assign mem_addr      = (state_q == S_REQ0) ? base_addr :
                           (state_q == S_REQ1) ? base_addr + AW'(NB) : '0;
    assign rsp_valid     = (state_q == S_RESP);
    assign rsp_data      = data_q;
    assign rsp_err       = err_q;

    // State and captured-load registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            op_q    <= LD_FULL;
            cross_q <= 1'b0;
            beat0_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            cross_q <= cross_d;
            beat0_q <= beat0_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: request capture, beat sequencing and response hold.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        cross_d = cross_q;
        beat0_d = beat0_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    op_d    = req_op_n;
                    cross_d = req_cross;
                    if (req_cross && (MISALIGN_EN == 0)) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_REQ0;
                    end
                end
            end
            S_REQ0: begin
                if (mem_req_ready) state_d = S_WAIT0;
            end
            S_WAIT0: begin
                if (mem_rsp_valid) begin
                    beat0_d = mem_rdata;
                    if (cross_q) begin
                        state_d = S_REQ1;
                    end else begin
                        data_d  = merged;
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end
                end
            end
            S_REQ1: begin
                if (mem_req_ready) state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (mem_rsp_valid) begin
                    data_d  = merged;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    data_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit (DW=32): one instance splits misaligned loads, one rejects them.
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_a, req_valid_b;
    logic [31:0] req_addr;
    logic [2:0]  req_op;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        rsp_ready;

    logic        req_ready_a, mem_req_valid_a, rsp_valid_a, rsp_err_a;
    logic [31:0] mem_addr_a, rsp_data_a;
    logic        req_ready_b, mem_req_valid_b, rsp_valid_b, rsp_err_b;
    logic [31:0] mem_addr_b, rsp_data_b;

    int tests = 0;
    int failed = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] req_log [$];
    int unsigned rsp_limit = 32'hFFFF_FFFF;
    int unsigned inject_req = 0;
    int unsigned inject_done;
    int unsigned rsp_count = 0;

    always #5 clk = ~clk;

    load_align_unit #(.DW(32), .AW(32), .MISALIGN_EN(1)) dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_addr(req_addr), .req_op(req_op), .mem_req_valid(mem_req_valid_a),
        .mem_req_ready(mem_req_ready), .mem_addr(mem_addr_a), .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_a), .rsp_err(rsp_err_a)
    );

    load_align_unit #(.DW(32), .AW(32), .MISALIGN_EN(0)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_addr(req_addr), .req_op(req_op), .mem_req_valid(mem_req_valid_b),
        .mem_req_ready(mem_req_ready), .mem_addr(mem_addr_b), .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_b), .rsp_err(rsp_err_b)
    );

    // Memory model: accepted request seen at one negedge, data pulse driven at the next.
    initial begin : responder
        logic        pending;
        logic [31:0] pend_data;
        logic [31:0] a;
        pending = 1'b0;
        pend_data = '0;
        inject_done = 0;
        mem_rsp_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pending) begin
                mem_rsp_valid = 1'b1;
                mem_rdata = pend_data;
            end else if (inject_done != inject_req) begin
                mem_rsp_valid = 1'b1;
                mem_rdata = 32'hFFFF_FFFF;
                inject_done++;
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rdata = '0;
            end
            pending = 1'b0;
            if ((mem_req_valid_a || mem_req_valid_b) && mem_req_ready && !reset) begin
                a = mem_req_valid_a ? mem_addr_a : mem_addr_b;
                req_log.push_back(a);
                if (req_log.size() <= rsp_limit) begin
                    pending = 1'b1;
                    pend_data = mem.exists(a) ? mem[a] : 32'h0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rsp_valid_a && rsp_ready) rsp_count++;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] base;
        base = {addr[31:2], 2'b00};
        mem[base] = w0;
        mem[base + 32'd4] = w1;
    endtask

    // Issue one load (called just after a posedge) and collect its response with rsp_ready high.
    task automatic do_load(input logic [31:0] addr, input logic [2:0] op, input bit use_b,
                           output logic [31:0] data, output logic err, output int lat,
                           output bit timeout);
        int w;
        bit got;
        timeout = 1'b0;
        data = '0;
        err = 1'b0;
        req_addr = addr;
        req_op = op;
        if (use_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        w = 0;
        @(negedge clk);
        while (!(use_b ? req_ready_b : req_ready_a) && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) timeout = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            if (use_b ? rsp_valid_b : rsp_valid_a) begin
                got = 1'b1;
                data = use_b ? rsp_data_b : rsp_data_a;
                err = use_b ? rsp_err_b : rsp_err_a;
            end else begin
                @(posedge clk);
                lat++;
            end
        end
        if (!got) timeout = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  op;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          use_b;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_nreq;
        logic [31:0] exp_a0;
        logic [31:0] exp_a1;
        int          exp_lat;
    } vec_t;

    initial begin : main
        vec_t        vecs[13];
        logic [31:0] d;
        logic        e;
        int          lat;
        bit          to;
        int          base;
        int unsigned cnt0;
        int          w;

        vecs[0]  = '{32'h0000_1003, 3'b010, 32'h80FF_1234, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b0, 1, 32'h0000_1000, 32'h0, 3};
        vecs[1]  = '{32'h0000_1002, 3'b011, 32'hBEEF_0000, 32'h0, 1'b0, 32'h0000_BEEF, 1'b0, 1, 32'h0000_1000, 32'h0, 3};
        vecs[2]  = '{32'h0000_1002, 3'b100, 32'hBEEF_0000, 32'h0, 1'b0, 32'hFFFF_BEEF, 1'b0, 1, 32'h0000_1000, 32'h0, 3};
        vecs[3]  = '{32'h0000_1001, 3'b000, 32'h4433_2211, 32'h8877_6655, 1'b0, 32'h5544_3322, 1'b0, 2, 32'h0000_1000, 32'h0000_1004, 5};
        vecs[4]  = '{32'hFFFF_FFFE, 3'b000, 32'h4433_2211, 32'h8877_6655, 1'b0, 32'h6655_4433, 1'b0, 2, 32'hFFFF_FFFC, 32'h0000_0000, 5};
        vecs[5]  = '{32'h0000_2001, 3'b001, 32'h1234_5678, 32'h0, 1'b0, 32'h0000_0056, 1'b0, 1, 32'h0000_2000, 32'h0, 3};
        vecs[6]  = '{32'h0000_1003, 3'b100, 32'hAB00_0000, 32'h0000_00CD, 1'b0, 32'hFFFF_CDAB, 1'b0, 2, 32'h0000_1000, 32'h0000_1004, 5};
        vecs[7]  = '{32'h0000_3000, 3'b111, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1, 32'h0000_3000, 32'h0, 3};
        vecs[8]  = '{32'h0000_3006, 3'b101, 32'h1111_2222, 32'h3333_4444, 1'b0, 32'h4444_1111, 1'b0, 2, 32'h0000_3004, 32'h0000_3008, 5};
        vecs[9]  = '{32'h0000_1000, 3'b010, 32'h0000_007F, 32'h0, 1'b0, 32'h0000_007F, 1'b0, 1, 32'h0000_1000, 32'h0, 3};
        vecs[10] = '{32'h0000_1003, 3'b100, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'h0000_0000, 1'b1, 0, 32'h0, 32'h0, 1};
        vecs[11] = '{32'h0000_1000, 3'b000, 32'hCAFE_F00D, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1, 32'h0000_1000, 32'h0, 3};
        vecs[12] = '{32'h0000_1002, 3'b011, 32'hBEEF_0000, 32'h0, 1'b1, 32'h0000_BEEF, 1'b0, 1, 32'h0000_1000, 32'h0, 3};

        reset = 1'b1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_addr = '0;
        req_op = '0;
        mem_req_ready = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(req_ready_a), 32'd1);
        check("reset mem_req_valid", 32'(mem_req_valid_a), 32'd0);
        check("reset mem_addr", mem_addr_a, 32'd0);
        check("reset rsp_valid", 32'(rsp_valid_a), 32'd0);
        check("reset rsp_data", rsp_data_a, 32'd0);
        check("reset rsp_err", 32'(rsp_err_a), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            preload(vecs[i].addr, vecs[i].w0, vecs[i].w1);
            base = req_log.size();
            do_load(vecs[i].addr, vecs[i].op, vecs[i].use_b, d, e, lat, to);
            check($sformatf("v%0d timeout", i), 32'(to), 32'd0);
            check($sformatf("v%0d rsp_data", i), d, vecs[i].exp_data);
            check($sformatf("v%0d rsp_err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d mem req count", i), 32'(req_log.size() - base), 32'(vecs[i].exp_nreq));
            if (vecs[i].exp_nreq >= 1 && req_log.size() > base)
                check($sformatf("v%0d addr beat0", i), req_log[base], vecs[i].exp_a0);
            if (vecs[i].exp_nreq == 2 && req_log.size() > base + 1)
                check($sformatf("v%0d addr beat1", i), req_log[base + 1], vecs[i].exp_a1);
        end

        // Back-pressure on both sides: address and result must hold, one response only.
        base = req_log.size();
        cnt0 = rsp_count;
        preload(32'h0000_1002, 32'hBEEF_0000, 32'h0);
        mem_req_ready = 1'b0;
        rsp_ready = 1'b0;
        req_addr = 32'h0000_1002;
        req_op = 3'b011;
        req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp mem_req_valid c%0d", k), 32'(mem_req_valid_a), 32'd1);
            check($sformatf("bp mem_addr c%0d", k), mem_addr_a, 32'h0000_1000);
            check($sformatf("bp req_ready c%0d", k), 32'(req_ready_a), 32'd0);
        end
        @(posedge clk);
        #1;
        mem_req_ready = 1'b1;
        w = 0;
        @(negedge clk);
        while (!rsp_valid_a && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("bp rsp wait", 32'(w >= 20), 32'd0);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("bp rsp_valid c%0d", k), 32'(rsp_valid_a), 32'd1);
            check($sformatf("bp rsp_data c%0d", k), rsp_data_a, 32'h0000_BEEF);
            check($sformatf("bp req_ready rsp c%0d", k), 32'(req_ready_a), 32'd0);
            @(posedge clk);
            #1;
            if (k == 1) rsp_ready = 1'b1;
            @(negedge clk);
        end
        check("bp rsp_data at handshake", rsp_data_a, 32'h0000_BEEF);
        @(posedge clk);
        @(negedge clk);
        check("bp rsp_valid after", 32'(rsp_valid_a), 32'd0);
        check("bp req_ready after", 32'(req_ready_a), 32'd1);
        check("bp response count", 32'(rsp_count - cnt0), 32'd1);
        check("bp mem req count", 32'(req_log.size() - base), 32'd1);

        // Reset while waiting on the second beat, then a stray memory response in IDLE.
        @(posedge clk);
        #1;
        base = req_log.size();
        rsp_limit = base + 1;
        preload(32'h0000_1001, 32'h4433_2211, 32'h8877_6655);
        req_addr = 32'h0000_1001;
        req_op = 3'b000;
        req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        w = 0;
        @(negedge clk);
        #1;
        while (req_log.size() < base + 2 && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("rst reach REQ1", 32'(w >= 20), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst req_ready", 32'(req_ready_a), 32'd1);
        check("rst mem_req_valid", 32'(mem_req_valid_a), 32'd0);
        check("rst mem_addr", mem_addr_a, 32'd0);
        check("rst rsp_valid", 32'(rsp_valid_a), 32'd0);
        check("rst rsp_data", rsp_data_a, 32'd0);
        check("rst rsp_err", 32'(rsp_err_a), 32'd0);
        rsp_limit = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        inject_req++;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("late rsp rsp_valid", 32'(rsp_valid_a), 32'd0);
        check("late rsp req_ready", 32'(req_ready_a), 32'd1);
        check("late rsp mem_req_valid", 32'(mem_req_valid_a), 32'd0);
        @(posedge clk);
        #1;
        preload(32'h0000_2000, 32'h0000_00AB, 32'h0);
        base = req_log.size();
        do_load(32'h0000_2000, 3'b001, 1'b0, d, e, lat, to);
        check("post-rst timeout", 32'(to), 32'd0);
        check("post-rst rsp_data", d, 32'h0000_00AB);
        check("post-rst rsp_err", 32'(e), 32'd0);
        check("post-rst latency", 32'(lat), 32'd3);
        check("post-rst mem req count", 32'(req_log.size() - base), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
